// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe
//   Pipelined instruction decoder. Raw words come in over a valid/ready
//   handshake. Each word is decoded combinationally into flag/oper/register/
//   immediate/memory fields and written into a DEPTH-entry in-order buffer.
//   The output ports always show the head record. They are all zero when the
//   buffer is empty or reset is asserted.
//
//   Optional feature macro: DECODE_STATS_EN
//     Adds the saturating 16-bit counters cnt_decoded and cnt_illegal.
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     in_valid     instruction word present
//     in_ready     decoder can accept a word (not in reset, buffer not full)
//     instruction  raw instruction word (INSTR_W bits)
//     out_valid    head entry valid
//     out_ready    consumer takes the head entry
//     flag, oper, rega, regb, intermed, mem_op, mem_addr, illegal
//                  decoded fields of the head entry
//     cnt_decoded  accepted words          (DECODE_STATS_EN only)
//     cnt_illegal  accepted illegal words  (DECODE_STATS_EN only)
module instr_decode_pipe #(
   parameter int REG_W   = 6,
   parameter int IMM_W   = 16,
   parameter int ADDR_W  = 10,
   parameter int INSTR_W = 30,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         flag,
   output logic [3:0]         oper,
   output logic [REG_W-1:0]   rega,
   output logic [REG_W-1:0]   regb,
   output logic [IMM_W-1:0]   intermed,
   output logic [1:0]         mem_op,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               illegal
`ifdef DECODE_STATS_EN
   ,
   output logic [15:0]        cnt_decoded,
   output logic [15:0]        cnt_illegal
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [1:0]        flag;
      logic [3:0]        oper;
      logic [REG_W-1:0]  rega;
      logic [REG_W-1:0]  regb;
      logic [IMM_W-1:0]  intermed;
      logic [1:0]        mem_op;
      logic [ADDR_W-1:0] mem_addr;
      logic              illegal;
   } rec_t;

   rec_t             dec;
   rec_t             head;
   rec_t             mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             accept;
   logic             consume;

   // Bits above the used fields are intentionally ignored.
   logic unused_instr;
   assign unused_instr = ^instruction;

   // ---------------------------------------------------------------------
   // Combinational decode of the incoming word
   // ---------------------------------------------------------------------
   always_comb begin
      dec      = '0;
      dec.flag = instruction[1:0];
      unique case (instruction[1:0])
         2'd1: begin
            dec.oper = instruction[5:2];
            dec.rega = instruction[6 +: REG_W];
            dec.regb = instruction[6+REG_W +: REG_W];
         end
         2'd2: begin
            dec.oper = instruction[5:2];
            unique case (instruction[5:2])
               4'd2: begin
                  dec.rega = instruction[6 +: REG_W];
                  dec.regb = instruction[6+REG_W +: REG_W];
               end
               4'd3: begin
                  dec.rega     = instruction[6 +: REG_W];
                  dec.intermed = instruction[6+REG_W +: IMM_W];
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         2'd3: begin
            dec.mem_op = instruction[3:2];
            if (instruction[3:2] == 2'd1 || instruction[3:2] == 2'd2) begin
               dec.rega     = instruction[4 +: REG_W];
               dec.mem_addr = instruction[4+REG_W +: ADDR_W];
            end else begin
               dec.mem_addr = instruction[4 +: ADDR_W];
               dec.intermed = instruction[4+ADDR_W +: IMM_W];
            end
         end
         default: ;  // NOP: all fields zero
      endcase
   end

   // ---------------------------------------------------------------------
   // In-order output buffer
   // ---------------------------------------------------------------------
   assign in_ready  = !rst && (count < (PTR_W+1)'(DEPTH));
   assign out_valid = !rst && (count != '0);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= dec;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (consume)
            rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({accept, consume})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   assign head     = out_valid ? mem[rd_ptr] : '0;
   assign flag     = head.flag;
   assign oper     = head.oper;
   assign rega     = head.rega;
   assign regb     = head.regb;
   assign intermed = head.intermed;
   assign mem_op   = head.mem_op;
   assign mem_addr = head.mem_addr;
   assign illegal  = head.illegal;

`ifdef DECODE_STATS_EN
   // ---------------------------------------------------------------------
   // Saturating accept statistics
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_decoded <= '0;
         cnt_illegal <= '0;
      end else if (accept) begin
         if (cnt_decoded != '1)
            cnt_decoded <= cnt_decoded + 16'd1;
         if (dec.illegal && cnt_illegal != '1)
            cnt_illegal <= cnt_illegal + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
module tb_instr_decode_pipe;

   localparam int REG_W   = 6;
   localparam int IMM_W   = 16;
   localparam int ADDR_W  = 10;
   localparam int INSTR_W = 30;
   localparam int DEPTH   = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instruction;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         flag;
   logic [3:0]         oper;
   logic [REG_W-1:0]   rega;
   logic [REG_W-1:0]   regb;
   logic [IMM_W-1:0]   intermed;
   logic [1:0]         mem_op;
   logic [ADDR_W-1:0]  mem_addr;
   logic               illegal;
`ifdef DECODE_STATS_EN
   logic [15:0]        cnt_decoded;
   logic [15:0]        cnt_illegal;
`endif

   instr_decode_pipe #(
      .REG_W(REG_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W),
      .INSTR_W(INSTR_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
      .out_valid(out_valid), .out_ready(out_ready),
      .flag(flag), .oper(oper), .rega(rega), .regb(regb),
      .intermed(intermed), .mem_op(mem_op), .mem_addr(mem_addr),
      .illegal(illegal)
`ifdef DECODE_STATS_EN
      , .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
`endif
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model: decoded records in a queue, counts as integers
   // ---------------------------------------------------------------------
   typedef struct {
      int unsigned flag, oper, rega, regb, imm, mop, addr, ill;
   } rec_t;

   rec_t        q[$];
   rec_t        zero_rec = '{default: 0};
   int unsigned m_dec = 0;
   int unsigned m_ill = 0;
   bit          model_accept = 1'b0;
   int unsigned tests = 0;
   int unsigned fails = 0;

   function automatic rec_t ref_decode(int unsigned w);
      rec_t r;
      int unsigned rm = (1 << REG_W) - 1;
      int unsigned im = (1 << IMM_W) - 1;
      int unsigned am = (1 << ADDR_W) - 1;
      r = '{default: 0};
      r.flag = w % 4;
      case (r.flag)
         1: begin
            r.oper = (w >> 2) % 16;
            r.rega = (w >> 6) & rm;
            r.regb = (w >> (6 + REG_W)) & rm;
         end
         2: begin
            r.oper = (w >> 2) % 16;
            if (r.oper == 2) begin
               r.rega = (w >> 6) & rm;
               r.regb = (w >> (6 + REG_W)) & rm;
            end else if (r.oper == 3) begin
               r.rega = (w >> 6) & rm;
               r.imm  = (w >> (6 + REG_W)) & im;
            end else begin
               r.ill = 1;
            end
         end
         3: begin
            r.mop = (w >> 2) % 4;
            if (r.mop == 1 || r.mop == 2) begin
               r.rega = (w >> 4) & rm;
               r.addr = (w >> (4 + REG_W)) & am;
            end else begin
               r.addr = (w >> 4) & am;
               r.imm  = (w >> (4 + ADDR_W)) & im;
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Compare process: every negedge, check outputs, then advance the model
   // to the state it must hold after the next posedge.
   // ---------------------------------------------------------------------
   rec_t e;
   bit   ev, acc, cons;

   initial begin
      forever begin
         @(negedge clk);
         ev = !rst && q.size() != 0;
         e  = ev ? q[0] : zero_rec;
         check("in_ready",  32'(in_ready),  32'(!rst && q.size() < DEPTH));
         check("out_valid", 32'(out_valid), 32'(ev));
         check("flag",      32'(flag),      e.flag);
         check("oper",      32'(oper),      e.oper);
         check("rega",      32'(rega),      e.rega);
         check("regb",      32'(regb),      e.regb);
         check("intermed",  32'(intermed),  e.imm);
         check("mem_op",    32'(mem_op),    e.mop);
         check("mem_addr",  32'(mem_addr),  e.addr);
         check("illegal",   32'(illegal),   e.ill);
`ifdef DECODE_STATS_EN
         check("cnt_decoded", 32'(cnt_decoded), m_dec);
         check("cnt_illegal", 32'(cnt_illegal), m_ill);
`endif
         if (rst) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
            model_accept = 1'b0;
         end else begin
            acc  = in_valid && q.size() < DEPTH;
            cons = ev && out_ready;
            if (cons) void'(q.pop_front());
            if (acc) begin
               e = ref_decode(32'(instruction));
               q.push_back(e);
               if (m_dec < 16'hFFFF) m_dec++;
               if (e.ill == 1 && m_ill < 16'hFFFF) m_ill++;
            end
            model_accept = acc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk);
         ok = model_accept;
      end
      #1 in_valid = 1'b0;
      check(name, 32'(ok), 1);
   endtask

   task automatic drive_word(input logic [INSTR_W-1:0] w);
      in_valid    = 1'b1;
      instruction = w;
      wait_accept("accept_timeout");
   endtask

   bit pending;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed decodes with hand-computed fields
      out_ready = 1'b1;
      drive_word(30'h00070D5);
      #1;
      check("t1_valid", 32'(out_valid), 1);
      check("t1_flag",  32'(flag), 1);
      check("t1_oper",  32'(oper), 5);
      check("t1_rega",  32'(rega), 3);
      check("t1_regb",  32'(regb), 7);
      check("t1_imm",   32'(intermed), 0);
      check("t1_ill",   32'(illegal), 0);

      drive_word(30'hBEEF04E);
      #1;
      check("t2_flag", 32'(flag), 2);
      check("t2_oper", 32'(oper), 3);
      check("t2_rega", 32'(rega), 1);
      check("t2_regb", 32'(regb), 0);
      check("t2_imm",  32'(intermed), 32'hBEEF);

      drive_word(30'h00A9497);
      #1;
      check("t3_flag", 32'(flag), 3);
      check("t3_mop",  32'(mem_op), 1);
      check("t3_rega", 32'(rega), 9);
      check("t3_addr", 32'(mem_addr), 32'h2A5);
      check("t3_imm",  32'(intermed), 0);

      drive_word(30'h000001E);
      #1;
      check("t4_flag", 32'(flag), 2);
      check("t4_oper", 32'(oper), 7);
      check("t4_ill",  32'(illegal), 1);
      check("t4_rega", 32'(rega), 0);
      check("t4_imm",  32'(intermed), 0);
`ifdef DECODE_STATS_EN
      check("t4_cnt_ill", 32'(cnt_illegal), 1);
      check("t4_cnt_dec", 32'(cnt_decoded), 4);
`endif
      @(posedge clk); #1;

      // Backpressure: fill the buffer, hold a third word, then drain
      out_ready = 1'b0;
      drive_word(30'h0001045);   // ALU oper 1
      drive_word(30'h0002089);   // ALU oper 2
      #1 check("full_in_ready", 32'(in_ready), 0);
      in_valid = 1'b1; instruction = 30'h00030CD;
      repeat (2) @(posedge clk);
      #1 check("held_in_ready", 32'(in_ready), 0);
      check("held_head_oper", 32'(oper), 1);
      out_ready = 1'b1;
      wait_accept("third_accept");
      repeat (4) @(posedge clk);
      #1;

      // Steady state with one entry: accept and consume every cycle
      out_ready = 1'b0;
      drive_word(30'($urandom));
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_word(30'($urandom));
         check("steady_valid", 32'(out_valid), 1);
         check("steady_ready", 32'(in_ready), 1);
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset with two entries buffered
      out_ready = 1'b0;
      drive_word(30'h0001045);
      drive_word(30'h0002089);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_flag",  32'(flag), 0);
      check("rst_oper",  32'(oper), 0);
      check("rst_ready", 32'(in_ready), 1);
`ifdef DECODE_STATS_EN
      check("rst_cnt_dec", 32'(cnt_decoded), 0);
      check("rst_cnt_ill", 32'(cnt_illegal), 0);
`endif
      @(posedge clk); #1;

      // Randomized traffic, source holds a word until it is accepted
      pending = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!(pending && !model_accept)) begin
            pending     = ($urandom % 4) != 0;
            instruction = 30'($urandom);
         end
         in_valid  = pending;
         out_ready = ($urandom % 3) != 0;
         rst       = ($urandom % 150) == 0;
         @(posedge clk);
         #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Parametrised, pipelined successor to the single-stage instruction decoder. Accepts raw instruction words over a valid/ready handshake and decodes them into register, immediate, memory-op and address fields. Results are held in a DEPTH-entry in-order output buffer so the execute stage can stall without losing instructions. Flags illegal encodings and sits between the fetch and execute/memory stages.

## Interface
- REG_W, 6, register index width
- IMM_W, 16, immediate width
- ADDR_W, 10, memory address width
- INSTR_W, 30, instruction width; must be ≥ max(6+2·REG_W, 6+REG_W+IMM_W, 4+REG_W+ADDR_W, 4+ADDR_W+IMM_W); bits above the used fields are ignored
- DEPTH, 2, output buffer entries; power of two, ≥2
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- in_valid  input  1  instruction word present
- in_ready  output  1  decoder can accept a word this cycle
- instruction  input  INSTR_W  raw instruction; bit 0 is LSB
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- flag  output  2  instruction class
- oper  output  4  ALU operation
- rega  output  REG_W  register A index
- regb  output  REG_W  register B index
- intermed  output  IMM_W  immediate
- mem_op  output  2  memory operation
- mem_addr  output  ADDR_W  memory address
- illegal  output  1  head entry is an illegal encoding
- cnt_decoded, cnt_illegal  output  16 each  present only with DECODE_STATS_EN

## Operation
- Field extraction (P = position): flag=[1:0].
- flag=0 NOP: emits an entry with all fields 0, illegal=0.
- flag=1 ALU reg-reg: oper=[5:2], rega=[6+REG_W-1:6], regb=next REG_W bits, intermed=0, mem_op=0, mem_addr=0.
- flag=2, oper=[5:2]:
  - oper=2 move: rega/regb as in flag=1.
  - oper=3 immediate: rega=[6+REG_W-1:6], intermed=next IMM_W bits, regb=0.
  - Any other oper: illegal=1, flag=2, oper kept, all other fields 0.
- flag=3 memory: mem_op=[3:2].
  - mem_op 1 (load) or 2 (store): rega=[4+REG_W-1:4], mem_addr=next ADDR_W bits, intermed=0.
  - mem_op 0 or 3: mem_addr=[4+ADDR_W-1:4], intermed=next IMM_W bits, rega=0.
  - In both cases oper=0 and regb=0.
- Decode is combinational on the input word. The decoded record is written into the buffer on accept (in_valid & in_ready).
- Buffer is a strict FIFO. The output ports always present the head record. When the buffer is empty, all field outputs and illegal are 0.
- A head record is consumed when out_valid & out_ready.

## Timing
- in_ready = !rst & (count < DEPTH).
- out_valid = count != 0.
- Latency: a word accepted in cycle N appears at the output (out_valid=1) in cycle N+1 when the buffer was empty.
- Simultaneous accept and consume: count is unchanged and order is preserved. When full, in_ready=0, so no accept occurs even if out_ready=1 that cycle; in_ready rises the cycle after the consume.
- Accept with in_valid high and in_ready low: the word is not captured. The source holds instruction stable until accepted.
- out_ready asserted with out_valid=0: ignored.
- Reset (any cycle, including mid-stream):
  - Clears count, read pointer and write pointer; pending entries are discarded.
  - All outputs are 0 (in_ready=0 while rst=1, 1 the cycle after).
  - Counters are cleared.
- Pointers wrap modulo DEPTH.

## Configuration
- DECODE_STATS_EN defined:
  - Adds cnt_decoded, which increments on every accept.
  - Adds cnt_illegal, which increments on every accept of an illegal word.
  - Both counters are 16 bits, saturate at 0xFFFF, and reset to 0.
- DECODE_STATS_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then push 0x00070D5 with out_ready=1 → next cycle out_valid=1, flag=1, oper=5, rega=3, regb=7, intermed=0, illegal=0.
- Push 0xBEEF04E → flag=2, oper=3, rega=1, regb=0, intermed=0xBEEF. Push 0x00A9497 → flag=3, mem_op=1, rega=9, mem_addr=0x2A5, intermed=0.
- Push 0x000001E → flag=2, oper=7, illegal=1, other fields 0. With DECODE_STATS_EN, cnt_illegal=1 after this accept.
- Hold out_ready=0 and push 3 words (DEPTH=2) → in_ready drops after the 2nd accept and the 3rd word is held. Release out_ready → outputs drain in order 1, 2, 3 with no loss or duplication.
- With count=1, assert in_valid and out_ready in the same cycle for 10 cycles → count stays 1 and the output sequence matches the input sequence shifted by one entry.
- Assert rst with 2 entries buffered → the next cycle has out_valid=0 and all fields 0. The cycle after reset deasserts, in_ready=1 and the counters read 0.
